// File: rtl/dm_stall_responder.sv
// dm_stall_responder: data-memory responder with programmable latency for the
// stall-capable pipeline. Accepts one request at a time, completes it LATENCY
// cycles later with a one-cycle Mem_ready pulse, and rejects misaligned,
// out-of-range or read+write requests with Mem_err instead of performing them.
module dm_stall_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           Mem_addr,
  input  logic [DATA_WIDTH-1:0] Mem_w_data,
  input  logic                  Mem_w,
  input  logic                  Mem_r,
  output logic [DATA_WIDTH-1:0] Mem_r_data,
  output logic                  Mem_ready,
  output logic                  Mem_err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    is_r_q, is_r_d;
  logic                    is_w_q, is_w_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic [31:0]             cur_addr;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic                    cur_r;
  logic                    cur_w;
  logic [AW-1:0]           cur_idx;
  logic                    cur_bad;
  logic [DATA_WIDTH-1:0]   mem_rword;
  logic                    mem_we;
  logic                    enter_done;

  // Request seen by the completion logic: with LATENCY=1 the request completes
  // on its accepting edge, before the latch holds it, so the live inputs are used.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = Mem_addr;
      cur_wdata = Mem_w_data;
      cur_r     = Mem_r;
      cur_w     = Mem_w;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_r     = is_r_q;
      cur_w     = is_w_q;
    end
    cur_idx   = cur_addr[AW+1:2];
    cur_bad   = (cur_addr[1:0] != 2'b00) || (|cur_addr[31:AW+2]) || (cur_r && cur_w);
    mem_rword = mem[cur_idx];
  end

  // Next-state, latency counter, request latch and completion outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_r_d     = is_r_q;
    is_w_d     = is_w_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    enter_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (Mem_r || Mem_w) begin
          addr_d  = Mem_addr;
          wdata_d = Mem_w_data;
          is_r_d  = Mem_r;
          is_w_d  = Mem_w;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter_done) begin
      ready_d = 1'b1;
      err_d   = cur_bad;
      if (cur_bad) begin
        rdata_d = '0;
      end else if (cur_w) begin
        mem_we = 1'b1;
      end else begin
        rdata_d = mem_rword;
      end
    end
  end

  // Control and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_r_q  <= 1'b0;
      is_w_q  <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_r_q  <= is_r_d;
      is_w_q  <= is_w_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array: not cleared by reset; written only on a valid write completion.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign Mem_r_data = rdata_q;
  assign Mem_ready  = ready_q;
  assign Mem_err    = err_q;

endmodule

// File: tb/tb_dm_stall_responder.sv
// Bench for dm_stall_responder: three instances (LATENCY 2, 1, 4) checked every
// cycle against a deadline-based reference model, plus directed literal checks.
module tb_dm_stall_responder;

  logic        clk;
  logic        rst   [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rd    [3];
  logic        r     [3];
  logic        w     [3];
  logic        rdy   [3];
  logic        err   [3];

  int checks   = 0;
  int failures = 0;
  int lats [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dm_stall_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .Mem_addr(addr[0]), .Mem_w_data(wd[0]), .Mem_w(w[0]),
    .Mem_r(r[0]), .Mem_r_data(rd[0]), .Mem_ready(rdy[0]), .Mem_err(err[0]));
  dm_stall_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[1]), .Mem_addr(addr[1]), .Mem_w_data(wd[1]), .Mem_w(w[1]),
    .Mem_r(r[1]), .Mem_r_data(rd[1]), .Mem_ready(rdy[1]), .Mem_err(err[1]));
  dm_stall_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst[2]), .Mem_addr(addr[2]), .Mem_w_data(wd[2]), .Mem_w(w[2]),
    .Mem_r(r[2]), .Mem_r_data(rd[2]), .Mem_ready(rdy[2]), .Mem_err(err[2]));

  // ---------------- reference model ----------------
  // Each accepted request finishes at a known edge number; memory contents are
  // tracked per instance, with a known-flag because the array has no reset value.
  int          edge_n = 0;
  bit          pend     [3];
  bit          in_done  [3];
  int          done_at  [3];
  logic [31:0] p_addr   [3];
  logic [31:0] p_wd     [3];
  bit          p_r      [3];
  bit          p_w      [3];
  bit          e_rdy    [3];
  bit          e_err    [3];
  logic [31:0] e_rd     [3];
  bit          e_known  [3];
  logic [31:0] mm       [3][256];
  bit          known    [3][256];

  function automatic void commit(int d);
    bit bad;
    int idx;
    bad = (p_addr[d] % 4 != 0) || (p_addr[d] >= 32'd1024) || (p_r[d] && p_w[d]);
    idx = int'(p_addr[d] / 4) % 256;
    e_rdy[d] = 1'b1;
    e_err[d] = bad;
    if (bad) begin
      e_rd[d]    = 32'h0;
      e_known[d] = 1'b1;
    end else if (p_w[d]) begin
      mm[d][idx]    = p_wd[d];
      known[d][idx] = 1'b1;
    end else begin
      e_rd[d]    = mm[d][idx];
      e_known[d] = known[d][idx];
    end
    pend[d]    = 1'b0;
    in_done[d] = 1'b1;
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      pend[d] = 0; in_done[d] = 0; done_at[d] = 0;
      e_rdy[d] = 0; e_err[d] = 0; e_rd[d] = '0; e_known[d] = 1;
      for (int i = 0; i < 256; i++) known[d][i] = 0;
    end
  end

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        pend[d] = 0; in_done[d] = 0;
        e_rdy[d] = 0; e_err[d] = 0; e_rd[d] = '0; e_known[d] = 1;
      end else if (in_done[d]) begin
        in_done[d] = 0; e_rdy[d] = 0; e_err[d] = 0;
      end else if (pend[d]) begin
        if (edge_n == done_at[d]) commit(d);
      end else if (r[d] || w[d]) begin
        p_addr[d] = addr[d]; p_wd[d] = wd[d]; p_r[d] = r[d]; p_w[d] = w[d];
        pend[d] = 1;
        done_at[d] = edge_n + lats[d] - 1;
        if (done_at[d] == edge_n) commit(d);
      end
    end
  end

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Every cycle, after the edge settles, all three instances against the model.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      check("ready", d, 32'(rdy[d]), 32'(e_rdy[d]));
      check("err", d, 32'(err[d]), 32'(e_err[d]));
      if (e_known[d]) check("rdata", d, rd[d], e_rd[d]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(int d, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      lat++;
      if (rdy[d]) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout dut%0d: got no Mem_ready expected pulse within 40 cycles", d);
    end
  endtask

  task automatic req(int d, bit rr, bit ww, logic [31:0] a, logic [31:0] dat, output int lat);
    @(negedge clk);
    r[d] = rr; w[d] = ww; addr[d] = a; wd[d] = dat;
    wait_ready(d, lat);
  endtask

  task automatic idle(int d, int n);
    @(negedge clk);
    r[d] = 0; w[d] = 0;
    repeat (n) @(posedge clk);
  endtask

  int lat;

  initial begin
    lats[0] = 2; lats[1] = 1; lats[2] = 4;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1; r[d] = 0; w[d] = 0; addr[d] = '0; wd[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_rdata", d, rd[d], 32'h0);
      check("reset_ready", d, 32'(rdy[d]), 32'h0);
      rst[d] = 0;
    end
    @(negedge clk);

    // LATENCY=2 write then read
    req(0, 0, 1, 32'h10, 32'hDEADBEEF, lat);
    check("l2_wr_lat", 0, lat, 2);
    check("l2_wr_err", 0, 32'(err[0]), 0);
    idle(0, 1);
    req(0, 1, 0, 32'h10, 32'h0, lat);
    check("l2_rd_lat", 0, lat, 2);
    check("l2_rd_data", 0, rd[0], 32'hDEADBEEF);
    check("l2_rd_err", 0, 32'(err[0]), 0);
    idle(0, 1);

    // LATENCY=1 back-to-back reads with the request held
    req(1, 0, 1, 32'h0, 32'h11111111, lat); idle(1, 1);
    req(1, 0, 1, 32'h4, 32'h22222222, lat); idle(1, 1);
    req(1, 1, 0, 32'h0, 32'h0, lat);
    check("l1_lat_first", 1, lat, 1);
    check("l1_rd0", 1, rd[1], 32'h11111111);
    req(1, 1, 0, 32'h4, 32'h0, lat);
    check("l1_b2b_gap", 1, lat, 2);
    check("l1_rd4", 1, rd[1], 32'h22222222);
    req(1, 1, 0, 32'h0, 32'h0, lat);
    check("l1_b2b_gap2", 1, lat, 2);
    check("l1_rd0_again", 1, rd[1], 32'h11111111);
    idle(1, 1);

    // misaligned read and out-of-range write
    req(0, 0, 1, 32'h0, 32'hA5A5A5A5, lat); idle(0, 1);
    req(0, 1, 0, 32'h10, 32'h0, lat); idle(0, 1);
    req(0, 1, 0, 32'h13, 32'h0, lat);
    check("misalign_err", 0, 32'(err[0]), 1);
    check("misalign_rdata", 0, rd[0], 32'h0);
    idle(0, 1);
    req(0, 0, 1, 32'h400, 32'hFFFFFFFF, lat);
    check("oor_err", 0, 32'(err[0]), 1);
    idle(0, 1);
    req(0, 1, 0, 32'h0, 32'h0, lat);
    check("word0_kept", 0, rd[0], 32'hA5A5A5A5);
    check("word0_err", 0, 32'(err[0]), 0);
    idle(0, 1);

    // simultaneous read and write
    req(0, 0, 1, 32'h8, 32'h0BADF00D, lat); idle(0, 1);
    req(0, 1, 1, 32'h8, 32'h55555555, lat);
    check("rw_both_err", 0, 32'(err[0]), 1);
    idle(0, 1);
    req(0, 1, 0, 32'h8, 32'h0, lat);
    check("rw_both_kept", 0, rd[0], 32'h0BADF00D);
    idle(0, 1);

    // LATENCY=4: reset during BUSY abandons the write
    req(2, 0, 1, 32'h20, 32'hCAFEF00D, lat);
    check("l4_lat", 2, lat, 4);
    idle(2, 1);
    req(2, 1, 0, 32'h20, 32'h0, lat); idle(2, 1);
    @(negedge clk);
    r[2] = 0; w[2] = 1; addr[2] = 32'h20; wd[2] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1; w[2] = 0;
    #1;
    check("rst_ready", 2, 32'(rdy[2]), 0);
    check("rst_rdata", 2, rd[2], 32'h0);
    repeat (2) @(negedge clk);
    rst[2] = 0;
    idle(2, 1);
    req(2, 1, 0, 32'h20, 32'h0, lat);
    check("rst_no_commit", 2, rd[2], 32'hCAFEF00D);
    idle(2, 1);

    // address changed while BUSY: latched address wins
    req(2, 0, 1, 32'h24, 32'h77777777, lat); idle(2, 1);
    @(negedge clk);
    r[2] = 1; w[2] = 0; addr[2] = 32'h20;
    @(posedge clk);
    @(negedge clk);
    addr[2] = 32'h24;
    wait_ready(2, lat);
    check("busy_addr_latched", 2, rd[2], 32'hCAFEF00D);
    idle(2, 1);

    // randomized traffic on all instances
    for (int i = 0; i < 300; i++) begin
      int d, sel;
      logic [31:0] a;
      bit rr, ww;
      d   = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 15));
      a   = 32'($urandom_range(0, 15)) * 4;
      if (sel == 0) a = a + 32'($urandom_range(1, 3));
      if (sel == 1) a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
      rr = $urandom_range(0, 1) == 1;
      ww = !rr;
      if (sel == 2) begin rr = 1; ww = 1; end
      req(d, rr, ww, a, $urandom, lat);
      if ($urandom_range(0, 1) == 1) idle(d, int'($urandom_range(0, 2)));
    end
    for (int d = 0; d < 3; d++) idle(d, 0);
    repeat (12) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
